// File: rtl/tron_round_ctrl.sv
// rtl/tron_round_ctrl.sv - round/match sequencer for the two-bike Tron arena
module tron_round_ctrl #(
    parameter int         FRAMES_PER_SEC = 60,
    parameter int         COUNT_SECS     = 3,
    parameter int         CRASH_FRAMES   = 120,
    parameter int         WIN_SCORE      = 3,
    parameter logic [7:0] START_KEY      = 8'h2C,
    parameter logic [7:0] ABORT_KEY      = 8'h29
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       collision_blue,
    input  logic       collision_red,
    output logic       arena_reset,
    output logic       arena_frame_clk,
    output logic       play_active,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [1:0] score_blue,
    output logic [1:0] score_red,
    output logic [1:0] round_winner,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_PLAY      = 3'd3,
        S_CRASH     = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [5:0] FRM_LOAD   = 6'(FRAMES_PER_SEC - 1);
    localparam logic [1:0] SEC_LOAD   = 2'(COUNT_SECS);
    localparam logic [7:0] CRASH_LOAD = 8'(CRASH_FRAMES - 1);
    localparam logic [1:0] WIN        = 2'(WIN_SCORE);

    state_t     st;
    logic       fq, fq2;
    logic [7:0] kq;
    logic [1:0] sec_cnt;
    logic [5:0] frm_cnt;
    logic [7:0] crash_cnt;
    logic [1:0] sb, sr, rw;

    logic tick, start_press, abort_press;

    assign tick        = fq & ~fq2;
    assign start_press = (keycode == START_KEY) && (kq != START_KEY);
    assign abort_press = (keycode == ABORT_KEY) && (kq != ABORT_KEY);

    // Frame clock edge detector and keycode history for press detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fq  <= 1'b0;
            fq2 <= 1'b0;
            kq  <= 8'h00;
        end else begin
            fq  <= frame_clk;
            fq2 <= fq;
            kq  <= keycode;
        end
    end

    // Round/match sequencer: countdown, play, crash pause and scoring
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            st        <= S_IDLE;
            sec_cnt   <= 2'd0;
            frm_cnt   <= 6'd0;
            crash_cnt <= 8'd0;
            sb        <= 2'd0;
            sr        <= 2'd0;
            rw        <= 2'b00;
        end else if (abort_press && st != S_IDLE) begin
            // Abort wins over any collision or tick in the same cycle
            st <= S_IDLE;
            sb <= 2'd0;
            sr <= 2'd0;
            rw <= 2'b00;
        end else begin
            case (st)
                S_IDLE, S_GAME_OVER: begin
                    if (start_press) begin
                        sb <= 2'd0;
                        sr <= 2'd0;
                        rw <= 2'b00;
                        st <= S_ARM;
                    end
                end
                S_ARM: begin
                    sec_cnt <= SEC_LOAD;
                    frm_cnt <= FRM_LOAD;
                    st      <= S_COUNTDOWN;
                end
                S_COUNTDOWN: begin
                    if (tick) begin
                        if (frm_cnt != 6'd0) begin
                            frm_cnt <= frm_cnt - 6'd1;
                        end else if (sec_cnt > 2'd1) begin
                            sec_cnt <= sec_cnt - 2'd1;
                            frm_cnt <= FRM_LOAD;
                        end else begin
                            st <= S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (collision_blue || collision_red) begin
                        st        <= S_CRASH;
                        crash_cnt <= CRASH_LOAD;
                        if (collision_blue && collision_red) begin
                            rw <= 2'b11;
                        end else if (collision_blue) begin
                            rw <= 2'b10;
                            if (sr < WIN) sr <= sr + 2'd1;
                        end else begin
                            rw <= 2'b01;
                            if (sb < WIN) sb <= sb + 2'd1;
                        end
                    end
                end
                S_CRASH: begin
                    if (tick) begin
                        if (crash_cnt == 8'd0) begin
                            st <= (sb == WIN || sr == WIN) ? S_GAME_OVER : S_ARM;
                        end else begin
                            crash_cnt <= crash_cnt - 8'd1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    // Moore decodes; arena_reset follows the async-cleared state immediately
    assign state           = st;
    assign arena_reset     = (st == S_IDLE) || (st == S_ARM);
    assign arena_frame_clk = fq2 & (st == S_PLAY);
    assign play_active     = (st == S_PLAY);
    assign countdown       = (st == S_COUNTDOWN) ? sec_cnt : 2'd0;
    assign score_blue      = sb;
    assign score_red       = sr;
    assign round_winner    = rw;
    assign game_over       = (st == S_GAME_OVER);

endmodule

// File: tb/tb_tron_round_ctrl.sv
// tb/tb_tron_round_ctrl.sv - directed testbench for tron_round_ctrl
module tb_tron_round_ctrl;

    logic       Clk, Reset, frame_clk;
    logic [7:0] keycode;
    logic       collision_blue, collision_red;
    logic       arena_reset, arena_frame_clk, play_active, game_over;
    logic [2:0] state;
    logic [1:0] countdown, score_blue, score_red, round_winner;

    int vectors = 0;
    int miscompares = 0;
    int fe_cnt = 0;
    int afc_rises = 0;
    int afc_bad = 0;
    int base, r0;

    tron_round_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .collision_blue(collision_blue), .collision_red(collision_red),
        .arena_reset(arena_reset), .arena_frame_clk(arena_frame_clk),
        .play_active(play_active), .state(state), .countdown(countdown),
        .score_blue(score_blue), .score_red(score_red),
        .round_winner(round_winner), .game_over(game_over)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // frame period of 8 Clk keeps the run short
    initial begin
        frame_clk = 1'b0;
        #2;
        forever #40 frame_clk = ~frame_clk;
    end

    always @(posedge frame_clk) fe_cnt++;
    always @(posedge arena_frame_clk) afc_rises++;
    always @(negedge Clk) if (!Reset && arena_frame_clk && state != 3'd3) afc_bad++;

    task automatic align();
        @(posedge frame_clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; keycode = 8'h00; collision_blue = 1'b0; collision_red = 1'b0;
        repeat (2) @(negedge Clk);
        vectors++;
        if ({state, arena_reset, arena_frame_clk, play_active, countdown, score_blue, score_red, round_winner, game_over}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=%b",
                {state, arena_reset, arena_frame_clk, play_active, countdown, score_blue, score_red, round_winner, game_over},
                {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0});
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_countdown();
        align();
        base = fe_cnt;
        keycode = 8'h2C;
        @(negedge Clk);
        keycode = 8'h00;
        vectors++;
        if ({state, arena_reset} !== {3'd1, 1'b1}) begin
            miscompares++; $display("FAIL arm_entry got=%b exp=%b", {state, arena_reset}, {3'd1, 1'b1});
        end
        @(negedge Clk);
        vectors++;
        if ({state, countdown, arena_reset, arena_frame_clk} !== {3'd2, 2'd3, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL countdown_entry got=%b exp=%b", {state, countdown, arena_reset, arena_frame_clk}, {3'd2, 2'd3, 1'b0, 1'b0});
        end
        collision_blue = 1'b1;
        @(negedge Clk);
        collision_blue = 1'b0;
        vectors++;
        if ({state, score_red, round_winner} !== {3'd2, 2'd0, 2'b00}) begin
            miscompares++; $display("FAIL countdown_collision_ignored got=%b exp=%b", {state, score_red, round_winner}, {3'd2, 2'd0, 2'b00});
        end
        for (int i = 0; i < 1000 && countdown != 2'd2; i++) @(negedge Clk);
        vectors++;
        if (fe_cnt - base !== 60 || countdown !== 2'd2) begin
            miscompares++; $display("FAIL countdown_to_2 got_ticks=%0d cd=%0d exp_ticks=60", fe_cnt - base, countdown);
        end
        for (int i = 0; i < 1000 && countdown != 2'd1; i++) @(negedge Clk);
        vectors++;
        if (fe_cnt - base !== 120 || countdown !== 2'd1) begin
            miscompares++; $display("FAIL countdown_to_1 got_ticks=%0d cd=%0d exp_ticks=120", fe_cnt - base, countdown);
        end
        for (int i = 0; i < 1000 && state != 3'd3; i++) @(negedge Clk);
        vectors++;
        if (fe_cnt - base !== 180 || state !== 3'd3) begin
            miscompares++; $display("FAIL play_entry got_ticks=%0d state=%0d exp_ticks=180", fe_cnt - base, state);
        end
        vectors++;
        if ({play_active, countdown, arena_reset} !== {1'b1, 2'd0, 1'b0}) begin
            miscompares++; $display("FAIL play_outputs got=%b exp=%b", {play_active, countdown, arena_reset}, {1'b1, 2'd0, 1'b0});
        end
        r0 = afc_rises;
        repeat (40) @(negedge Clk);
        vectors++;
        if (afc_rises - r0 !== 5) begin
            miscompares++; $display("FAIL play_frame_clk_rises got=%0d exp=5", afc_rises - r0);
        end
    endtask

    task automatic test_crash_blue();
        align();
        base = fe_cnt;
        collision_blue = 1'b1;
        @(negedge Clk);
        collision_blue = 1'b0;
        vectors++;
        if ({state, score_red, score_blue, round_winner, arena_reset} !== {3'd4, 2'd1, 2'd0, 2'b10, 1'b0}) begin
            miscompares++; $display("FAIL crash_blue got=%b exp=%b", {state, score_red, score_blue, round_winner, arena_reset}, {3'd4, 2'd1, 2'd0, 2'b10, 1'b0});
        end
        for (int i = 0; i < 2000 && state != 3'd1; i++) @(negedge Clk);
        vectors++;
        if (fe_cnt - base !== 120 || state !== 3'd1) begin
            miscompares++; $display("FAIL crash_length got_ticks=%0d state=%0d exp_ticks=120", fe_cnt - base, state);
        end
        @(negedge Clk);
        vectors++;
        if (state !== 3'd2) begin
            miscompares++; $display("FAIL crash_rearm got=%0d exp=2", state);
        end
        for (int i = 0; i < 3000 && state != 3'd3; i++) @(negedge Clk);
    endtask

    task automatic test_draw();
        collision_blue = 1'b1; collision_red = 1'b1;
        @(negedge Clk);
        collision_blue = 1'b0; collision_red = 1'b0;
        vectors++;
        if ({state, round_winner, score_red, score_blue} !== {3'd4, 2'b11, 2'd1, 2'd0}) begin
            miscompares++; $display("FAIL draw got=%b exp=%b", {state, round_winner, score_red, score_blue}, {3'd4, 2'b11, 2'd1, 2'd0});
        end
        for (int i = 0; i < 2000 && state != 3'd1; i++) @(negedge Clk);
        for (int i = 0; i < 3000 && state != 3'd3; i++) @(negedge Clk);
    endtask

    task automatic test_game_over();
        collision_blue = 1'b1;
        @(negedge Clk);
        collision_blue = 1'b0;
        vectors++;
        if ({state, score_red} !== {3'd4, 2'd2}) begin
            miscompares++; $display("FAIL second_red_win got=%b exp=%b", {state, score_red}, {3'd4, 2'd2});
        end
        for (int i = 0; i < 2000 && state != 3'd1; i++) @(negedge Clk);
        for (int i = 0; i < 3000 && state != 3'd3; i++) @(negedge Clk);
        collision_blue = 1'b1;
        @(negedge Clk);
        collision_blue = 1'b0;
        repeat (20) @(negedge Clk);
        keycode = 8'h2C;
        for (int i = 0; i < 2000 && state != 3'd5; i++) @(negedge Clk);
        vectors++;
        if ({state, game_over, score_red, score_blue, round_winner, arena_reset, arena_frame_clk}
            !== {3'd5, 1'b1, 2'd3, 2'd0, 2'b10, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL game_over got=%b exp=%b",
                {state, game_over, score_red, score_blue, round_winner, arena_reset, arena_frame_clk},
                {3'd5, 1'b1, 2'd3, 2'd0, 2'b10, 1'b0, 1'b0});
        end
        repeat (10) @(negedge Clk);
        vectors++;
        if ({state, score_red} !== {3'd5, 2'd3}) begin
            miscompares++; $display("FAIL held_start_no_restart got=%b exp=%b", {state, score_red}, {3'd5, 2'd3});
        end
        keycode = 8'h00;
        @(negedge Clk);
        keycode = 8'h2C;
        @(negedge Clk);
        keycode = 8'h00;
        vectors++;
        if ({state, score_red, score_blue, round_winner, game_over} !== {3'd1, 2'd0, 2'd0, 2'b00, 1'b0}) begin
            miscompares++; $display("FAIL restart got=%b exp=%b", {state, score_red, score_blue, round_winner, game_over}, {3'd1, 2'd0, 2'd0, 2'b00, 1'b0});
        end
    endtask

    task automatic test_abort();
        repeat (100) @(negedge Clk);
        keycode = 8'h29;
        @(negedge Clk);
        keycode = 8'h00;
        vectors++;
        if ({state, arena_reset, countdown} !== {3'd0, 1'b1, 2'd0}) begin
            miscompares++; $display("FAIL abort_countdown got=%b exp=%b", {state, arena_reset, countdown}, {3'd0, 1'b1, 2'd0});
        end
        keycode = 8'h2C;
        @(negedge Clk);
        keycode = 8'h00;
        for (int i = 0; i < 3000 && state != 3'd3; i++) @(negedge Clk);
        collision_red = 1'b1;
        @(negedge Clk);
        collision_red = 1'b0;
        vectors++;
        if ({state, score_blue, score_red, round_winner} !== {3'd4, 2'd1, 2'd0, 2'b01}) begin
            miscompares++; $display("FAIL crash_red got=%b exp=%b", {state, score_blue, score_red, round_winner}, {3'd4, 2'd1, 2'd0, 2'b01});
        end
        for (int i = 0; i < 2000 && state != 3'd1; i++) @(negedge Clk);
        for (int i = 0; i < 3000 && state != 3'd3; i++) @(negedge Clk);
        keycode = 8'h29; collision_blue = 1'b1;
        @(negedge Clk);
        keycode = 8'h00; collision_blue = 1'b0;
        vectors++;
        if ({state, score_blue, score_red, round_winner, arena_reset} !== {3'd0, 2'd0, 2'd0, 2'b00, 1'b1}) begin
            miscompares++; $display("FAIL abort_over_collision got=%b exp=%b", {state, score_blue, score_red, round_winner, arena_reset}, {3'd0, 2'd0, 2'd0, 2'b00, 1'b1});
        end
        @(negedge Clk);
        vectors++;
        if ({state, score_red} !== {3'd0, 2'd0}) begin
            miscompares++; $display("FAIL abort_stays_idle got=%b exp=%b", {state, score_red}, {3'd0, 2'd0});
        end
    endtask

    task automatic test_async_reset();
        keycode = 8'h2C;
        @(negedge Clk);
        keycode = 8'h00;
        for (int i = 0; i < 3000 && state != 3'd3; i++) @(negedge Clk);
        vectors++;
        if (state !== 3'd3) begin
            miscompares++; $display("FAIL async_setup_play got=%0d exp=3", state);
        end
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if ({state, arena_reset, play_active, arena_frame_clk} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL async_reset got=%b exp=%b", {state, arena_reset, play_active, arena_frame_clk}, {3'd0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge Clk);
        Reset = 1'b0;
        collision_red = 1'b1;
        @(negedge Clk);
        collision_red = 1'b0;
        vectors++;
        if ({state, score_blue, round_winner} !== {3'd0, 2'd0, 2'b00}) begin
            miscompares++; $display("FAIL idle_collision_ignored got=%b exp=%b", {state, score_blue, round_winner}, {3'd0, 2'd0, 2'b00});
        end
        vectors++;
        if (afc_bad !== 0) begin
            miscompares++; $display("FAIL frame_clk_outside_play got=%0d exp=0", afc_bad);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_crash_blue();
        test_draw();
        test_game_over();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tron_round_ctrl.md
Name: tron_round_ctrl

Overview:
- Round/match sequencer for the two-bike Tron arena.
- Holds the arena in reset until a start key, runs a countdown, then passes frame ticks to the arena only while a round is live.
- Captures the arena's collision pulses, scores the round, freezes the bikes for a crash pause, and re-arms until one player reaches WIN_SCORE.
- Sits between the keyboard/VGA frame source and the arena; its outputs drive the arena reset, the arena frame clock and the HUD.

Parameters:
- FRAMES_PER_SEC, 60, frame ticks per countdown second (6-bit frame counter).
- COUNT_SECS, 3, countdown length in seconds (1..3).
- CRASH_FRAMES, 120, frame ticks the bikes stay frozen after a crash (8-bit counter).
- WIN_SCORE, 3, round wins needed to end the match (1..3).
- START_KEY, 8'h2C, keycode (space) that starts or restarts a match.
- ABORT_KEY, 8'h29, keycode (Esc) that aborts to IDLE.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high; all state cleared immediately.
- frame_clk  in  1  ~60 Hz frame clock, same as fed to VGA.
- keycode  in  8  current keyboard keycode (level).
- collision_blue  in  1  arena blue-crash pulse, 1 Clk wide.
- collision_red  in  1  arena red-crash pulse, 1 Clk wide.
- arena_reset  out  1  drives the arena Reset.
- arena_frame_clk  out  1  gated frame clock to the arena.
- play_active  out  1  round live.
- state  out  3  encoded FSM state for HUD/debug.
- countdown  out  2  seconds remaining (3..1) during COUNTDOWN, else 0.
- score_blue  out  2  blue round wins.
- score_red  out  2  red round wins.
- round_winner  out  2  last round result: 00 none, 01 blue, 10 red, 11 draw.
- game_over  out  1  match finished.

Behaviour:
- **Reset values:** state=IDLE(0), arena_reset=1, arena_frame_clk=0, play_active=0, countdown=0, scores=0, round_winner=00, game_over=0.
- **Frame tick:** frame_clk registered once (fq), then again (fq2). tick = fq & ~fq2, a single Clk pulse.
- **Gated frame clock:** arena_frame_clk = fq registered AND (state==PLAY). It is glitch-free and lags frame_clk by 2 Clk.
- **Key press:** key_press(K) = (keycode==K) & (keycode_q!=K), where keycode_q is keycode registered. Holding a key never re-triggers.
- **Output decode:** all outputs are Moore decodes of registered state and counters.
- **IDLE (0):** arena_reset=1.
  - START press: scores←0, round_winner←00, go to ARM.
- **ARM (1):** exactly 1 Clk; arena_reset=1.
  - Load sec_cnt=COUNT_SECS and frm_cnt=FRAMES_PER_SEC-1, then go to COUNTDOWN.
- **COUNTDOWN (2):** arena_reset=0, arena_frame_clk held 0; countdown=sec_cnt.
  - On tick: if frm_cnt≠0, decrement frm_cnt.
  - Else, if sec_cnt>1: decrement sec_cnt and reload frm_cnt.
  - Else go to PLAY.
  - Duration is exactly COUNT_SECS×FRAMES_PER_SEC ticks.
- **PLAY (3):** play_active=1; frame ticks reach the arena.
  - On a collision pulse, go to CRASH and load crash_cnt=CRASH_FRAMES-1.
  - blue only → red scores, round_winner=10.
  - red only → blue scores, round_winner=01.
  - both in the same Clk → draw, no score change, round_winner=11.
  - Scores saturate at WIN_SCORE.
- **CRASH (4):** arena_reset=0 and arena_frame_clk=0, so the bikes freeze at the crash position.
  - On tick, decrement crash_cnt.
  - On the tick with crash_cnt==0: if either score==WIN_SCORE go to GAME_OVER, else go to ARM.
- **GAME_OVER (5):** game_over=1; bikes stay frozen; scores and round_winner held.
  - START press: scores←0, round_winner←00, go to ARM.
- **ABORT press:** in any state except IDLE, go to IDLE next Clk with scores←0 and round_winner←00.
  - ABORT takes priority over a collision or tick in the same Clk.
- **Out-of-state events:** collision pulses outside PLAY are ignored.
- **Ticks on entry:** a tick in the same Clk as entry into COUNTDOWN/CRASH is ignored; counting starts with the next tick.
- **Unused encodings:** 6 and 7 return to IDLE.
- **Reset mid-round:** asynchronous Reset returns to IDLE; arena_reset asserts in the same cycle, without waiting for a Clk edge.

Test Plan:
1. Reset, then keycode=8'h2C for 1 Clk → ARM for 1 Clk with arena_reset=1. Then COUNTDOWN shows countdown 3,2,1 for 60 ticks each; PLAY entered on tick 180; arena_frame_clk toggles only in PLAY.
2. In PLAY, 1-Clk collision_blue → CRASH, score_red=1, round_winner=10, arena_frame_clk stays 0 for 120 ticks, then ARM → COUNTDOWN.
3. Same-Clk collision_blue and collision_red → round_winner=11, scores unchanged, CRASH entered.
4. Red wins 3 rounds → after the third CRASH, GAME_OVER with game_over=1 and score_red=3. Holding 8'h2C across entry causes no restart; release then press → scores 0, ARM.
5. keycode=8'h29 mid-COUNTDOWN and again in the same Clk as a collision in PLAY → IDLE next Clk, scores 0, arena_reset=1, collision ignored.
6. Async Reset pulse between Clk edges during PLAY → state=0, arena_reset=1, play_active=0 immediately; collision pulses during IDLE/COUNTDOWN → no score change.
